// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions: hazard FSM states, forwarding select codes and
// the register-write match helper used by the forwarding selectors.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    INT_SEQ  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] SP_ADDR = 2'b11;

  // A stage writes src if it writes its dest port there, or writes SP and src is SP.
  function automatic logic writes_reg(input logic [1:0] wen, input logic [1:0] dest,
                                      input logic [1:0] src);
    return (wen[0] && (src == dest)) || (wen[1] && (src == SP_ADDR));
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// EX operand forwarding select for one source operand; MEM is the newer
// producer so it wins over WB.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic       valid_ex,
  input  logic [1:0] src_ex,
  input  logic [1:0] dest_mem,
  input  logic [1:0] wen_mem,
  input  logic [1:0] dest_wb,
  input  logic [1:0] wen_wb,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (valid_ex) begin
      if (writes_reg(wen_mem, dest_mem, src_ex)) begin
        fwd = FWD_MEM;
      end else if (writes_reg(wen_wb, dest_wb, src_ex)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stall/flush generation, RET recovery and
// interrupt-entry sequencing, plus per-operand EX forwarding selects.
module hazard_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int RET_LAT = 2,
  parameter int INT_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] s1D,
  input  logic [1:0] s2D,
  input  logic       valids1_D,
  input  logic       valids2_D,
  input  logic [1:0] s1EX,
  input  logic [1:0] s2EX,
  input  logic       valids1_EX,
  input  logic       valids2_EX,
  input  logic [1:0] dest_addrEX,
  input  logic [1:0] reg_file_wenEX,
  input  logic       D_mem_renEX,
  input  logic [1:0] dest_addrMEM,
  input  logic [1:0] reg_file_wenMEM,
  input  logic [1:0] dest_addrWB,
  input  logic [1:0] reg_file_wenWB,
  input  logic       branch_takenEX,
  input  logic       RET_enEX,
  input  logic       intr,
  output logic       stallF,
  output logic       stallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       load_stallD,
  output logic       int_inject,
  output logic [1:0] fwd_s1,
  output logic [1:0] fwd_s2
);

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       pend_reg, pend_next;
  logic       load_use;
  logic       take_intr;

  logic       src_valid [2];
  logic [1:0] src_addr  [2];
  logic [1:0] fwd_sel_q [2];

  assign load_use = D_mem_renEX & reg_file_wenEX[0] &
                    ((valids1_D & (s1D == dest_addrEX)) | (valids2_D & (s2D == dest_addrEX)));

  // Interrupt entry only when no higher-priority hazard claims the RUN cycle.
  assign take_intr = (state_reg == RUN) & ~RET_enEX & ~branch_takenEX & ~load_use & pend_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= 3'd0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg | intr;
    case (state_reg)
      RUN: begin
        if (RET_enEX) begin
          if (RET_LAT > 1) begin
            state_next = RET_WAIT;
            cnt_next   = 3'(RET_LAT - 1);
          end
        end else if (take_intr) begin
          pend_next = 1'b0;
          if (INT_LEN > 1) begin
            state_next = INT_SEQ;
            cnt_next   = 3'(INT_LEN - 1);
          end
        end
      end
      RET_WAIT, INT_SEQ: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_next == 3'd0) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_comb begin
    stallF      = 1'b0;
    stallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    load_stallD = 1'b0;
    int_inject  = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (RET_enEX || branch_takenEX) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_use) begin
            stallF      = 1'b1;
            stallD      = 1'b1;
            FlushE      = 1'b1;
            load_stallD = 1'b1;
          end else if (take_intr) begin
            int_inject = 1'b1;
            stallF     = 1'b1;
          end
        end
        RET_WAIT: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
        INT_SEQ: begin
          int_inject = 1'b1;
          stallF     = 1'b1;
        end
        default: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
      endcase
    end
  end

  assign src_valid[0] = valids1_EX;
  assign src_valid[1] = valids2_EX;
  assign src_addr[0]  = s1EX;
  assign src_addr[1]  = s2EX;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel u_fwd_sel (
        .valid_ex (src_valid[gi]),
        .src_ex   (src_addr[gi]),
        .dest_mem (dest_addrMEM),
        .wen_mem  (reg_file_wenMEM),
        .dest_wb  (dest_addrWB),
        .wen_wb   (reg_file_wenWB),
        .fwd      (fwd_sel_q[gi])
      );
    end
  endgenerate

  assign fwd_s1 = rst_n ? fwd_sel_q[0] : FWD_RF;
  assign fwd_s2 = rst_n ? fwd_sel_q[1] : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed and randomized checks of hazard_ctrl_unit against a cycle-count
// reference model of the hazard rules.
module tb_hazard_ctrl_unit;

  localparam int RET_LAT = 2;
  localparam int INT_LEN = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] s1D, s2D, s1EX, s2EX, dest_ex, wen_ex, dest_mem, wen_mem, dest_wb, wen_wb;
  logic       v1D, v2D, v1EX, v2EX, ren_ex, br, ret, intr;
  logic       stallF, stallD, FlushD, FlushE, load_stallD, int_inject;
  logic [1:0] fwd_s1, fwd_s2;

  int n_checks = 0;
  int n_errors = 0;

  // Model: remaining forced-flush cycles, remaining inject cycles, pending interrupt.
  int m_ret_left = 0;
  int m_int_left = 0;
  bit m_pend     = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.RET_LAT(RET_LAT), .INT_LEN(INT_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .s1D(s1D), .s2D(s2D), .valids1_D(v1D), .valids2_D(v2D),
    .s1EX(s1EX), .s2EX(s2EX), .valids1_EX(v1EX), .valids2_EX(v2EX),
    .dest_addrEX(dest_ex), .reg_file_wenEX(wen_ex), .D_mem_renEX(ren_ex),
    .dest_addrMEM(dest_mem), .reg_file_wenMEM(wen_mem),
    .dest_addrWB(dest_wb), .reg_file_wenWB(wen_wb),
    .branch_takenEX(br), .RET_enEX(ret), .intr(intr),
    .stallF(stallF), .stallD(stallD), .FlushD(FlushD), .FlushE(FlushE),
    .load_stallD(load_stallD), .int_inject(int_inject),
    .fwd_s1(fwd_s1), .fwd_s2(fwd_s2)
  );

  // Output vector: {stallF, stallD, FlushD, FlushE, load_stallD, int_inject, fwd_s1, fwd_s2}
  function automatic logic [9:0] observed();
    return {stallF, stallD, FlushD, FlushE, load_stallD, int_inject, fwd_s1, fwd_s2};
  endfunction

  function automatic logic [1:0] fwd_model(input logic v, input logic [1:0] src,
                                           input logic [1:0] dm, input logic [1:0] wm,
                                           input logic [1:0] dw, input logic [1:0] ww);
    bit mem_hit, wb_hit;
    mem_hit = (wm[0] && src == dm) || (wm[1] && src == 2'd3);
    wb_hit  = (ww[0] && src == dw) || (ww[1] && src == 2'd3);
    if (!v) return 2'd0;
    if (mem_hit) return 2'd1;
    if (wb_hit) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit load_use_now();
    return ren_ex && wen_ex[0] && ((v1D && s1D == dest_ex) || (v2D && s2D == dest_ex));
  endfunction

  function automatic logic [9:0] model_out();
    logic [9:0] o;
    o = '0;
    if (!rst_n) return 10'b0011000000;
    o[3:2] = fwd_model(v1EX, s1EX, dest_mem, wen_mem, dest_wb, wen_wb);
    o[1:0] = fwd_model(v2EX, s2EX, dest_mem, wen_mem, dest_wb, wen_wb);
    if (m_ret_left > 0)      o[7:6] = 2'b11;
    else if (m_int_left > 0) begin o[9] = 1'b1; o[4] = 1'b1; end
    else if (ret || br)      o[7:6] = 2'b11;
    else if (load_use_now()) begin o[9:8] = 2'b11; o[6] = 1'b1; o[5] = 1'b1; end
    else if (m_pend)         begin o[9] = 1'b1; o[4] = 1'b1; end
    return o;
  endfunction

  task automatic model_advance();
    if (!rst_n) begin
      m_ret_left = 0; m_int_left = 0; m_pend = 0;
    end else if (m_ret_left > 0) begin
      m_ret_left--; m_pend = m_pend | intr;
    end else if (m_int_left > 0) begin
      m_int_left--; m_pend = m_pend | intr;
    end else if (ret) begin
      m_ret_left = RET_LAT - 1; m_pend = m_pend | intr;
    end else if (br || load_use_now()) begin
      m_pend = m_pend | intr;
    end else if (m_pend) begin
      m_int_left = INT_LEN - 1; m_pend = 0;
    end else begin
      m_pend = intr;
    end
  endtask

  task automatic idle_inputs();
    {s1D, s2D, s1EX, s2EX, dest_ex, wen_ex, dest_mem, wen_mem, dest_wb, wen_wb} = '0;
    {v1D, v2D, v1EX, v2EX, ren_ex, br, ret, intr} = '0;
  endtask

  // Check current outputs against the model (and an explicit value when given), then advance one cycle.
  task automatic step(input string tag, input bit has_exp, input logic [9:0] exp);
    logic [9:0] obs, mdl;
    #1;
    obs = observed();
    mdl = model_out();
    n_checks++;
    assert (obs === mdl) else begin
      n_errors++;
      $error("FAIL %s model: observed %b expected %b", tag, obs, mdl);
    end
    if (has_exp) begin
      n_checks++;
      assert (obs === exp) else begin
        n_errors++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
    end
    $display("step %-12s in ret=%b br=%b ren=%b intr=%b out=%b", tag, ret, br, ren_ex, intr, obs);
    model_advance();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    step("reset0", 1, 10'b0011000000);
    step("reset1", 1, 10'b0011000000);
    rst_n = 1'b1;
    step("idle", 1, 10'b0000000000);

    // load-use on source 1
    ren_ex = 1; wen_ex = 2'b01; dest_ex = 2'd2; s1D = 2'd2; v1D = 1;
    step("load_use", 1, 10'b1101100000);
    idle_inputs();
    step("lu_clear", 1, 10'b0000000000);

    // branch with a simultaneous load-use
    ren_ex = 1; wen_ex = 2'b01; dest_ex = 2'd1; s2D = 2'd1; v2D = 1; br = 1;
    step("br_lu", 1, 10'b0011000000);
    idle_inputs();

    // RET, then interrupt raised during the recovery window
    ret = 1;
    step("ret_c1", 1, 10'b0011000000);
    ret = 0; intr = 1;
    step("ret_c2", 1, 10'b0011000000);
    intr = 0;
    step("ret_int1", 1, 10'b1000010000);
    step("ret_int2", 1, 10'b1000010000);
    step("ret_done", 1, 10'b0000000000);

    // single-cycle interrupt pulse in RUN
    intr = 1;
    step("int_pulse", 1, 10'b0000000000);
    intr = 0;
    step("int_c1", 1, 10'b1000010000);
    step("int_c2", 1, 10'b1000010000);
    step("int_done", 1, 10'b0000000000);

    // forwarding: MEM wins, then WB, then SP write via WB
    s1EX = 2'd1; v1EX = 1; dest_mem = 2'd1; wen_mem = 2'b01; dest_wb = 2'd1; wen_wb = 2'b01;
    step("fwd_mem", 1, 10'b0000000100);
    wen_mem = 2'b00;
    step("fwd_wb", 1, 10'b0000001000);
    v1EX = 0; s2EX = 2'd3; v2EX = 1; dest_wb = 2'd0; wen_wb = 2'b10;
    step("fwd_sp", 1, 10'b0000000010);
    v2EX = 0;
    step("fwd_inval", 1, 10'b0000000000);
    idle_inputs();

    // reset in the middle of RET recovery with an interrupt pending
    ret = 1;
    step("ret_rst", 1, 10'b0011000000);
    ret = 0; intr = 1;
    #2 rst_n = 1'b0;
    step("async_rst", 1, 10'b0011000000);
    intr = 0;
    rst_n = 1'b1;
    step("post_rst1", 1, 10'b0000000000);
    step("post_rst2", 1, 10'b0000000000);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      s1D      = 2'($urandom_range(0, 3));
      s2D      = 2'($urandom_range(0, 3));
      s1EX     = 2'($urandom_range(0, 3));
      s2EX     = 2'($urandom_range(0, 3));
      dest_ex  = 2'($urandom_range(0, 3));
      dest_mem = 2'($urandom_range(0, 3));
      dest_wb  = 2'($urandom_range(0, 3));
      wen_ex   = 2'($urandom_range(0, 3));
      wen_mem  = 2'($urandom_range(0, 3));
      wen_wb   = 2'($urandom_range(0, 3));
      v1D      = 1'($urandom_range(0, 1));
      v2D      = 1'($urandom_range(0, 1));
      v1EX     = 1'($urandom_range(0, 1));
      v2EX     = 1'($urandom_range(0, 1));
      ren_ex   = ($urandom_range(0, 2) == 0);
      br       = ($urandom_range(0, 7) == 0);
      ret      = ($urandom_range(0, 9) == 0);
      intr     = ($urandom_range(0, 7) == 0);
      step("random", 0, 10'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
